// File: rtl/sumsqr_credit.sv
// Credit-based launch gate and result FIFO for the fixed-latency sum-of-squares pipe.
// Launches are allowed only when a FIFO slot is reserved for the result that returns SUMSQR_LAT cycles later.
module sumsqr_credit #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 8,
  parameter int SUMSQR_LAT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         launch,
  input  logic                         res_valid,
  input  logic [WIDTH-1:0]             res_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (SUMSQR_LAT > 0) ? $clog2(SUMSQR_LAT + 1) : 1;

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [DW-1:0] LAT_L    = DW'(SUMSQR_LAT);

  logic [LW-1:0]    credits_q, credits_d;
  logic [LW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]    drop_q, drop_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic pop;
  logic accept;
  logic full;
  logic wr_en;

  // in_ready is gated by reset so nothing can launch while state is held cleared
  assign in_ready  = (credits_q != '0) & ~reset;
  assign launch    = in_valid & in_ready;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = count_q;
  assign overflow  = overflow_q;

  assign pop    = out_valid & out_ready;
  assign accept = res_valid & (drop_q == '0);
  assign full   = (count_q == DEPTH_L);
  assign wr_en  = accept & ~full;

  always_comb begin
    credits_d = credits_q;
    if (launch && !pop)
      credits_d = credits_q - LW'(1);
    else if (pop && !launch && (credits_q != DEPTH_L))
      credits_d = credits_q + LW'(1);
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)
      count_d = count_q + LW'(1);
    else if (pop && !wr_en)
      count_d = count_q - LW'(1);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en)
      mem_d[wr_ptr_q] = res_data;
  end

  // results still in flight from before a reset emerge during this window and are discarded
  always_comb begin
    drop_d = drop_q;
    if (drop_q != '0)
      drop_d = drop_q - DW'(1);
  end

  assign overflow_d = overflow_q | (accept & full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q  <= DEPTH_L;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= LAT_L;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

endmodule
